// File: rtl/topk_tracker_if.sv
// Bus bundle for topk_tracker: sample input, rank select and tracked-rank outputs.
// The master drives the samples and the slave is the tracker.
interface topk_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
) ();
  localparam int RSW = (K > 1) ? $clog2(K) : 1;
  localparam int CW  = $clog2(K + 1);

  logic                    clear;
  logic                    din_valid;
  logic [DATA_WIDTH-1:0]   din;
  logic [RSW-1:0]          rank_sel;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    dout_valid;
  logic [K*DATA_WIDTH-1:0] topk;
  logic [CW-1:0]           count;
  logic                    full;

  modport master (
    output clear, din_valid, din, rank_sel,
    input  dout, dout_valid, topk, count, full
  );

  modport slave (
    input  clear, din_valid, din, rank_sel,
    output dout, dout_valid, topk, count, full
  );
endinterface

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: a sorted register array of the K most extreme samples.
// Each slot compares din in parallel; the resulting thermometer selects insert-vs-shift.

module topk_tracker_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int MIN_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  take_prev,
  input  logic [DATA_WIDTH-1:0] prev_val,
  input  logic                  prev_vld,
  output logic [DATA_WIDTH-1:0] val,
  output logic                  vld,
  output logic                  take
);
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  vld_q, vld_d;

  // An empty slot is always taken; ties never beat, so equal values land below.
  assign take = !vld_q || ((MIN_MODE != 0) ? (din < val_q) : (din > val_q));
  assign val  = val_q;
  assign vld  = vld_q;

  always_comb begin
    val_d = val_q;
    vld_d = vld_q;
    if (clear) begin
      val_d = '0;
      vld_d = 1'b0;
    end else if (din_valid && take) begin
      if (take_prev) begin
        val_d = prev_val;
        vld_d = prev_vld;
      end else begin
        val_d = din;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      val_q <= '0;
      vld_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
    end
  end
endmodule

module topk_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter int MIN_MODE   = 0
) (
  input  logic          clk,
  input  logic          resetn,
  topk_tracker_if.slave bus
);
  localparam int RSW = (K > 1) ? $clog2(K) : 1;
  localparam int RW  = RSW + 1;
  localparam int CW  = $clog2(K + 1);

  logic [K-1:0][DATA_WIDTH-1:0] val, prev_val;
  logic [K-1:0]                 vld, prev_vld, take, take_prev;
  logic [CW-1:0]                count_q, count_d;

  // Slot i receives slot i-1 when the thermometer bit above it is also set.
  always_comb begin
    take_prev = '0;
    prev_val  = '0;
    prev_vld  = '0;
    for (int i = 1; i < K; i++) begin
      take_prev[i] = take[i-1];
      prev_val[i]  = val[i-1];
      prev_vld[i]  = vld[i-1];
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_slot
    topk_tracker_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .MIN_MODE   (MIN_MODE)
    ) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (bus.clear),
      .din_valid (bus.din_valid),
      .din       (bus.din),
      .take_prev (take_prev[i]),
      .prev_val  (prev_val[i]),
      .prev_vld  (prev_vld[i]),
      .val       (val[i]),
      .vld       (vld[i]),
      .take      (take[i])
    );
  end

  // take is a thermometer, so any insert at all sets the last bit.
  always_comb begin
    count_d = count_q;
    if (bus.clear)
      count_d = '0;
    else if (bus.din_valid && take[K-1] && (count_q != CW'(K)))
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign bus.count = count_q;
  assign bus.full  = (count_q == CW'(K));

  always_comb begin
    bus.topk       = '0;
    bus.dout       = '0;
    bus.dout_valid = 1'b0;
    for (int i = 0; i < K; i++) begin
      bus.topk[i*DATA_WIDTH +: DATA_WIDTH] = vld[i] ? val[i] : '0;
      if ({1'b0, bus.rank_sel} == RW'(i)) begin
        bus.dout       = vld[i] ? val[i] : '0;
        bus.dout_valid = vld[i];
      end
    end
  end
endmodule
